// File: rtl/hazard_ctrl_mc_if.sv
// Hazard controller bundle: datapath-sourced register fields/flags in,
// pipeline stall/flush/forward controls and status out.
interface hazard_ctrl_mc_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
);
  logic [AW-1:0]    Rs1D, Rs2D;
  logic             UseRs1D, UseRs2D;
  logic [AW-1:0]    Rs1E, Rs2E, RdE;
  logic             LoadE, PCSrcE, MulDivStartE, MulDivDoneE;
  logic [AW-1:0]    RdM;
  logic             RegWriteM, MemReadyM;
  logic [AW-1:0]    RdW;
  logic             RegWriteW;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushM, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MulDivBusy, MdTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output Rs1D, Rs2D, UseRs1D, UseRs2D, Rs1E, Rs2E, RdE, LoadE, PCSrcE,
           MulDivStartE, MulDivDoneE, RdM, RegWriteM, MemReadyM, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           ForwardAE, ForwardBE, MulDivBusy, MdTimeout, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, UseRs1D, UseRs2D, Rs1E, Rs2E, RdE, LoadE, PCSrcE,
           MulDivStartE, MulDivDoneE, RdM, RegWriteM, MemReadyM, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           ForwardAE, ForwardBE, MulDivBusy, MdTimeout, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline with mul/div
// wait FSM, memory wait-state freeze and saturating stall/flush counters.
module hazard_ctrl_mc #(
  parameter int unsigned AW             = 5,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned MD_TIMEOUT     = 64,
  parameter int unsigned ZERO_FWD_BLOCK = 1
) (
  input  logic            clk,
  input  logic            reset,
  hazard_ctrl_mc_if.slave hz
);
  localparam int unsigned WCW = $clog2(MD_TIMEOUT + 1);
  localparam logic [WCW-1:0]   WC_MAX  = WCW'(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, MD_WAIT} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall, md_stall, lw_stall, br_flush;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;

  // M stage wins over W; register 0 optionally never forwards
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                         input logic [AW-1:0] rd_m, input logic wr_m,
                                         input logic [AW-1:0] rd_w, input logic wr_w);
    fwd_sel = 2'b00;
    if ((ZERO_FWD_BLOCK != 0) && (rs == '0)) fwd_sel = 2'b00;
    else if (wr_m && (rs == rd_m))           fwd_sel = 2'b10;
    else if (wr_w && (rs == rd_w))           fwd_sel = 2'b01;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
    br_flush = 1'b0;

    lw_stall  = hz.LoadE && (hz.RdE != '0) &&
                ((hz.UseRs1D && (hz.Rs1D == hz.RdE)) ||
                 (hz.UseRs2D && (hz.Rs2D == hz.RdE)));
    mem_stall = !hz.MemReadyM;
    md_stall  = ((state_q == MD_WAIT) || hz.MulDivStartE) && !hz.MulDivDoneE;

    // Freeze on memory wait: FSM holds, so transitions need MemReadyM
    unique case (state_q)
      RUN:     if (hz.MulDivStartE && !hz.MulDivDoneE && hz.MemReadyM) state_d = MD_WAIT;
      MD_WAIT: if (hz.MulDivDoneE && hz.MemReadyM) state_d = RUN;
      default: state_d = RUN;
    endcase

    if ((state_q == RUN) && (state_d == MD_WAIT)) begin
      wait_cnt_d = '0;
    end else if ((state_q == MD_WAIT) && (wait_cnt_q != WC_MAX)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
    if ((state_q == MD_WAIT) && (wait_cnt_d == WC_MAX)) timeout_d = 1'b1;

    if (reset) begin
      stall_f = 1'b0;
    end else if (mem_stall) begin
      stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (md_stall) begin
      stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d  = 1'b1; flush_e = 1'b1;
      br_flush = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1; stall_d = 1'b1;
      flush_e = 1'b1;
    end

    if (stall_f && (stall_cnt_q != CNT_MAX))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (br_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushM     = flush_m;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE  = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.MulDivBusy = !reset && (state_q == MD_WAIT);
  assign hz.MdTimeout  = timeout_q;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: a default instance and a small one
// (CNT_W=3, MD_TIMEOUT=4) driven by the same stimulus.
module tb_hazard_ctrl_mc;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.AW(5), .CNT_W(16)) if0 ();
  hazard_ctrl_mc_if #(.AW(5), .CNT_W(3))  if1 ();

  hazard_ctrl_mc #(.AW(5), .CNT_W(16), .MD_TIMEOUT(64), .ZERO_FWD_BLOCK(1))
    u0 (.clk(clk), .reset(reset), .hz(if0));
  hazard_ctrl_mc #(.AW(5), .CNT_W(3), .MD_TIMEOUT(4), .ZERO_FWD_BLOCK(1))
    u1 (.clk(clk), .reset(reset), .hz(if1));

  assign if1.Rs1D         = if0.Rs1D;
  assign if1.Rs2D         = if0.Rs2D;
  assign if1.UseRs1D      = if0.UseRs1D;
  assign if1.UseRs2D      = if0.UseRs2D;
  assign if1.Rs1E         = if0.Rs1E;
  assign if1.Rs2E         = if0.Rs2E;
  assign if1.RdE          = if0.RdE;
  assign if1.LoadE        = if0.LoadE;
  assign if1.PCSrcE       = if0.PCSrcE;
  assign if1.MulDivStartE = if0.MulDivStartE;
  assign if1.MulDivDoneE  = if0.MulDivDoneE;
  assign if1.RdM          = if0.RdM;
  assign if1.RegWriteM    = if0.RegWriteM;
  assign if1.MemReadyM    = if0.MemReadyM;
  assign if1.RdW          = if0.RdW;
  assign if1.RegWriteW    = if0.RegWriteW;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if0.Rs1D = '0; if0.Rs2D = '0; if0.UseRs1D = 1'b0; if0.UseRs2D = 1'b0;
    if0.Rs1E = '0; if0.Rs2E = '0; if0.RdE = '0;
    if0.LoadE = 1'b0; if0.PCSrcE = 1'b0;
    if0.MulDivStartE = 1'b0; if0.MulDivDoneE = 1'b0;
    if0.RdM = '0; if0.RegWriteM = 1'b0; if0.MemReadyM = 1'b1;
    if0.RdW = '0; if0.RegWriteW = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    if0.PCSrcE = 1'b1;
    #1;
    chk("rst_flushd", 32'(if0.FlushD), 32'd0);
    chk("rst_busy", 32'(if0.MulDivBusy), 32'd0);
    tick();
    idle();
    reset = 1'b0;
    #1;
    chk("rst_stallcnt", 32'(if0.StallCount), 32'd0);
    chk("rst_flushcnt", 32'(if0.FlushCount), 32'd0);
    chk("rst_timeout", 32'(if0.MdTimeout), 32'd0);
    chk("rst_stallf", 32'(if0.StallF), 32'd0);

    // Forwarding
    if0.RdM = 5'd5; if0.RdW = 5'd5; if0.RegWriteM = 1'b1; if0.RegWriteW = 1'b1;
    if0.Rs1E = 5'd5; if0.Rs2E = 5'd0;
    #1;
    chk("fwd_a_m", 32'(if0.ForwardAE), 32'd2);
    chk("fwd_b_zero", 32'(if0.ForwardBE), 32'd0);
    if0.RegWriteM = 1'b0;
    #1;
    chk("fwd_a_w", 32'(if0.ForwardAE), 32'd1);
    if0.RdW = 5'd0;
    #1;
    chk("fwd_b_zero_w", 32'(if0.ForwardBE), 32'd0);
    chk("fwd_a_none", 32'(if0.ForwardAE), 32'd0);
    idle();

    // Load-use on Rs2
    if0.LoadE = 1'b1; if0.RdE = 5'd7; if0.Rs2D = 5'd7; if0.UseRs2D = 1'b1;
    #1;
    chk("lw_stallf", 32'(if0.StallF), 32'd1);
    chk("lw_stalld", 32'(if0.StallD), 32'd1);
    chk("lw_flushe", 32'(if0.FlushE), 32'd1);
    chk("lw_flushd", 32'(if0.FlushD), 32'd0);
    tick();
    chk("lw_stallcnt", 32'(if0.StallCount), 32'd1);
    if0.UseRs2D = 1'b0;
    #1;
    chk("lw_nouse", 32'(if0.StallF), 32'd0);
    tick();
    chk("lw_nouse_cnt", 32'(if0.StallCount), 32'd1);
    idle();

    // Mul/div: start at cycle 0, done at cycle 4
    if0.MulDivStartE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("md_stallf", 32'(if0.StallF), 32'd1);
      chk("md_flushm", 32'(if0.FlushM), 32'd1);
      chk("md_busy", 32'(if0.MulDivBusy), (i > 0) ? 32'd1 : 32'd0);
      tick();
    end
    if0.MulDivDoneE = 1'b1;
    #1;
    chk("md_done_stallf", 32'(if0.StallF), 32'd0);
    chk("md_done_flushm", 32'(if0.FlushM), 32'd0);
    tick();
    idle();
    #1;
    chk("md_run_busy", 32'(if0.MulDivBusy), 32'd0);
    chk("md_stallcnt", 32'(if0.StallCount), 32'd5);

    // Branch beats load-use
    if0.PCSrcE = 1'b1; if0.LoadE = 1'b1; if0.RdE = 5'd7;
    if0.Rs1D = 5'd7; if0.UseRs1D = 1'b1;
    #1;
    chk("br_flushd", 32'(if0.FlushD), 32'd1);
    chk("br_flushe", 32'(if0.FlushE), 32'd1);
    chk("br_stallf", 32'(if0.StallF), 32'd0);
    chk("br_stalld", 32'(if0.StallD), 32'd0);
    tick();
    chk("br_flushcnt", 32'(if0.FlushCount), 32'd1);
    idle();

    // Memory wait while in MD_WAIT with a taken branch
    if0.MulDivStartE = 1'b1;
    tick();
    if0.MemReadyM = 1'b0; if0.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mem_stallm", 32'(if0.StallM), 32'd1);
      chk("mem_flushw", 32'(if0.FlushW), 32'd1);
      chk("mem_flushd", 32'(if0.FlushD), 32'd0);
      chk("mem_flushe", 32'(if0.FlushE), 32'd0);
      chk("mem_flushm", 32'(if0.FlushM), 32'd0);
      chk("mem_busy", 32'(if0.MulDivBusy), 32'd1);
      tick();
    end
    if0.MemReadyM = 1'b1; if0.PCSrcE = 1'b0; if0.MulDivDoneE = 1'b1;
    #1;
    chk("mem_done_stallf", 32'(if0.StallF), 32'd0);
    tick();
    idle();
    #1;
    chk("mem_flushcnt", 32'(if0.FlushCount), 32'd1);
    chk("mem_stallcnt", 32'(if0.StallCount), 32'd9);
    chk("mem_busy_end", 32'(if0.MulDivBusy), 32'd0);

    // Reset in MD_WAIT
    if0.MulDivStartE = 1'b1;
    tick();
    chk("rmd_busy", 32'(if0.MulDivBusy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rmd_busy_rst", 32'(if0.MulDivBusy), 32'd0);
    chk("rmd_stallf_rst", 32'(if0.StallF), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rmd_busy_after", 32'(if0.MulDivBusy), 32'd0);
    chk("rmd_stallcnt", 32'(if0.StallCount), 32'd0);
    chk("rmd_flushcnt", 32'(if0.FlushCount), 32'd0);
    chk("rmd_timeout1", 32'(if1.MdTimeout), 32'd0);

    // Timeout on the MD_TIMEOUT=4 instance
    if0.MulDivStartE = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("to_before", 32'(if1.MdTimeout), 32'd0);
    tick();
    chk("to_set", 32'(if1.MdTimeout), 32'd1);
    chk("to_busy", 32'(if1.MulDivBusy), 32'd1);
    chk("to_u0_clear", 32'(if0.MdTimeout), 32'd0);
    if0.MulDivDoneE = 1'b1;
    tick();
    idle();
    #1;
    chk("to_sticky", 32'(if1.MdTimeout), 32'd1);
    chk("to_run", 32'(if1.MulDivBusy), 32'd0);

    // Saturation of the 3-bit counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("sat_rst_to", 32'(if1.MdTimeout), 32'd0);
    if0.LoadE = 1'b1; if0.RdE = 5'd7; if0.Rs1D = 5'd7; if0.UseRs1D = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_u1", 32'(if1.StallCount), 32'd7);
    chk("sat_u0", 32'(if0.StallCount), 32'd10);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
